// File: rtl/debug_pos_stepper_if.sv
// Button/position bundle between the board-side driver and debug_pos_stepper.
// The master drives the buttons and the load. The slave (the stepper) drives the position and its flags.
interface debug_pos_stepper_if #(
  parameter int WIDTH = 17
);
  logic                    up;
  logic                    down;
  logic                    coarse;
  logic                    load;
  logic signed [WIDTH-1:0] load_val;
  logic signed [WIDTH-1:0] pos;
  logic                    step_pulse;
  logic                    step_dir;
  logic                    at_min;
  logic                    at_max;

  modport master (
    output up, down, coarse, load, load_val,
    input  pos, step_pulse, step_dir, at_min, at_max
  );

  modport slave (
    input  up, down, coarse, load, load_val,
    output pos, step_pulse, step_dir, at_min, at_max
  );
endinterface

// File: rtl/debug_pos_stepper.sv
// Debounced up/down stepper for a signed debug coordinate. It supports fine/coarse steps,
// hold-to-repeat, clamping to [MIN_POS, MAX_POS] and an external load that overrides a step.
module debug_pos_stepper #(
  parameter int WIDTH         = 17,
  parameter int STEP_FINE     = 1,
  parameter int STEP_COARSE   = 480,
  parameter int MIN_POS       = 10,
  parameter int MAX_POS       = 30250,
  parameter int RESET_POS     = 10,
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  debug_pos_stepper_if.slave bus
);

  localparam int EW      = WIDTH + 2;
  localparam int DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int TMAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int HOLD_M1 = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  localparam logic signed [EW-1:0]    C_MIN    = EW'(MIN_POS);
  localparam logic signed [EW-1:0]    C_MAX    = EW'(MAX_POS);
  localparam logic signed [EW-1:0]    C_FINE   = EW'(STEP_FINE);
  localparam logic signed [EW-1:0]    C_COARSE = EW'(STEP_COARSE);
  localparam logic signed [WIDTH-1:0] C_MIN_W  = WIDTH'(MIN_POS);
  localparam logic signed [WIDTH-1:0] C_MAX_W  = WIDTH'(MAX_POS);
  localparam logic signed [WIDTH-1:0] C_RST_W  = WIDTH'(RESET_POS);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD_UP, S_HOLD_DN, S_RPT_UP, S_RPT_DN, S_LOCK
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_deb;
  assign w_raw = {bus.down, bus.up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]    r_sync;
      logic [DW-1:0] r_cnt;
      logic          r_deb;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_sync <= '0;
          r_cnt  <= '0;
          r_deb  <= 1'b0;
        end else begin
          r_sync <= {r_sync[0], w_raw[gi]};
          if (r_sync[1] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
            r_cnt <= '0;
            r_deb <= ~r_deb;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_deb[gi] = r_deb;
    end
  endgenerate

  state_t            r_state, w_state_next;
  logic [TW-1:0]     r_timer;
  logic              w_u, w_d, w_step, w_step_up, w_tmr_clr, w_hold_hit, w_rpt_hit;

  assign w_u        = w_deb[0];
  assign w_d        = w_deb[1];
  assign w_hold_hit = (HOLD_CYCLES != 0) && (r_timer == TW'(HOLD_M1));
  assign w_rpt_hit  = (r_timer == TW'(REPEAT_CYCLES - 1));

  // IDLE is only reachable with the pressed button low, so a level there is a fresh press.
  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    w_step_up    = 1'b0;
    w_tmr_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmr_clr = 1'b1;
        if (w_u && w_d) begin
          w_state_next = S_LOCK;
        end else if (w_u) begin
          w_step = 1'b1; w_step_up = 1'b1; w_state_next = S_HOLD_UP;
        end else if (w_d) begin
          w_step = 1'b1; w_state_next = S_HOLD_DN;
        end
      end
      S_HOLD_UP, S_RPT_UP: begin
        if (w_d) begin
          w_state_next = S_LOCK;
        end else if (!w_u) begin
          w_state_next = S_IDLE;
        end else if ((r_state == S_HOLD_UP) ? w_hold_hit : w_rpt_hit) begin
          w_step = 1'b1; w_step_up = 1'b1; w_tmr_clr = 1'b1; w_state_next = S_RPT_UP;
        end
      end
      S_HOLD_DN, S_RPT_DN: begin
        if (w_u) begin
          w_state_next = S_LOCK;
        end else if (!w_d) begin
          w_state_next = S_IDLE;
        end else if ((r_state == S_HOLD_DN) ? w_hold_hit : w_rpt_hit) begin
          w_step = 1'b1; w_tmr_clr = 1'b1; w_state_next = S_RPT_DN;
        end
      end
      S_LOCK: begin
        w_tmr_clr = 1'b1;
        if (!w_u && !w_d) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  logic signed [WIDTH-1:0] r_pos;
  logic                    r_step_pulse, r_step_dir, r_at_min, r_at_max;
  logic signed [EW-1:0]    w_pos_ext, w_ld_ext, w_step_val;
  logic signed [EW-1:0]    w_up_val, w_dn_val, w_up_clamp, w_dn_clamp, w_ld_clamp, w_target;
  logic signed [WIDTH-1:0] w_target_pos, w_pos_next;
  logic                    w_apply, w_change;

  // Two guard bits keep pos +/- step and wide loads from wrapping before the clamp.
  assign w_pos_ext    = EW'(r_pos);
  assign w_ld_ext     = EW'(bus.load_val);
  assign w_step_val   = bus.coarse ? C_COARSE : C_FINE;
  assign w_up_val     = w_pos_ext + w_step_val;
  assign w_dn_val     = w_pos_ext - w_step_val;
  assign w_up_clamp   = (w_up_val > C_MAX) ? C_MAX : w_up_val;
  assign w_dn_clamp   = (w_dn_val < C_MIN) ? C_MIN : w_dn_val;
  assign w_ld_clamp   = (w_ld_ext < C_MIN) ? C_MIN : ((w_ld_ext > C_MAX) ? C_MAX : w_ld_ext);
  assign w_target     = bus.load ? w_ld_clamp : (w_step_up ? w_up_clamp : w_dn_clamp);
  assign w_target_pos = w_target[WIDTH-1:0];
  assign w_apply      = bus.load || w_step;
  assign w_change     = w_apply && (w_target_pos != r_pos);
  assign w_pos_next   = w_change ? w_target_pos : r_pos;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_pos        <= C_RST_W;
      r_step_pulse <= 1'b0;
      r_step_dir   <= 1'b1;
      r_at_min     <= (RESET_POS == MIN_POS);
      r_at_max     <= (RESET_POS == MAX_POS);
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_tmr_clr ? '0 : r_timer + 1'b1;
      r_pos        <= w_pos_next;
      r_step_pulse <= w_change;
      if (w_step && !bus.load) r_step_dir <= w_step_up;
      r_at_min     <= (w_pos_next == C_MIN_W);
      r_at_max     <= (w_pos_next == C_MAX_W);
    end
  end

  assign bus.pos        = r_pos;
  assign bus.step_pulse = r_step_pulse;
  assign bus.step_dir   = r_step_dir;
  assign bus.at_min     = r_at_min;
  assign bus.at_max     = r_at_max;

endmodule

// File: tb/tb_debug_pos_stepper.sv
// Directed bench for debug_pos_stepper with short debounce/hold/repeat windows.
// It covers glitch rejection, hold-repeat cadence, clamping, lock-out and load priority.
module tb_debug_pos_stepper;

  localparam int WIDTH = 17;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  debug_pos_stepper_if #(.WIDTH(WIDTH)) bus ();

  debug_pos_stepper #(
    .WIDTH(WIDTH), .DEB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Each tick returns 1 time unit after a rising edge, where inputs change and outputs are sampled.
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = WIDTH'(v);
    tick(1);
    bus.load     = 1'b0;
    $display("load %0d -> pos %0d pulse %0d", v, bus.pos, bus.step_pulse);
  endtask

  int exp_pos;
  bit upd;
  int dn_exp[6] = '{14, 13, 12, 11, 10, 10};

  initial begin
    bus.up = 1'b0; bus.down = 1'b0; bus.coarse = 1'b0;
    bus.load = 1'b0; bus.load_val = '0;

    tick(3);
    check("rst_pos", bus.pos, 10);
    check("rst_pulse", bus.step_pulse, 0);
    check("rst_dir", bus.step_dir, 1);
    check("rst_at_min", bus.at_min, 1);
    check("rst_at_max", bus.at_max, 0);
    sys_rst_n = 1'b1;
    tick(2);

    // A 3-cycle pulse is shorter than the debounce window.
    bus.up = 1'b1; tick(3); bus.up = 1'b0; tick(10);
    check("glitch_pos", bus.pos, 10);
    check("glitch_pulse", bus.step_pulse, 0);
    $display("glitch -> pos %0d", bus.pos);

    // Coarse hold: first step at +7, first repeat at +17, then every 5, up to the release tail.
    bus.coarse = 1'b1; bus.up = 1'b1; exp_pos = 10;
    for (int c = 1; c <= 50; c++) begin
      tick(1);
      upd = (c == 7) || (c >= 17 && c <= 42 && ((c - 17) % 5) == 0);
      if (upd) exp_pos += 480;
      check($sformatf("rpt_pos@%0d", c), bus.pos, exp_pos);
      check($sformatf("rpt_pulse@%0d", c), bus.step_pulse, int'(upd));
      if (c == 40) bus.up = 1'b0;
    end
    $display("hold-repeat -> pos %0d", bus.pos);
    check("rpt_final", bus.pos, 3370);

    do_load(30000);
    check("ld_pos", bus.pos, 30000);
    check("ld_pulse", bus.step_pulse, 1);
    check("ld_dir", bus.step_dir, 1);
    check("ld_at_max", bus.at_max, 0);

    bus.up = 1'b1; tick(7);
    check("max_pos", bus.pos, 30250);
    check("max_pulse", bus.step_pulse, 1);
    check("max_at_max", bus.at_max, 1);
    $display("up to max -> pos %0d", bus.pos);
    bus.up = 1'b0; tick(10);

    bus.up = 1'b1; tick(7);
    check("max2_pos", bus.pos, 30250);
    check("max2_pulse", bus.step_pulse, 0);
    check("max2_at_max", bus.at_max, 1);
    $display("up at max -> pos %0d", bus.pos);
    bus.up = 1'b0; tick(10);

    // Fine down presses into the lower clamp.
    bus.coarse = 1'b0;
    do_load(15);
    check("ld15_pos", bus.pos, 15);
    for (int i = 0; i < 6; i++) begin
      bus.down = 1'b1; tick(7);
      check($sformatf("dn%0d_pos", i), bus.pos, dn_exp[i]);
      check($sformatf("dn%0d_at_min", i), bus.at_min, int'(i >= 4));
      check($sformatf("dn%0d_pulse", i), bus.step_pulse, int'(i < 5));
      check($sformatf("dn%0d_dir", i), bus.step_dir, 0);
      $display("down press %0d -> pos %0d", i, bus.pos);
      bus.down = 1'b0; tick(10);
    end

    // Load lands on the cycle the up step is decided; the step is dropped and dir is kept.
    bus.up = 1'b1; tick(6);
    check("pri_pre_pos", bus.pos, 10);
    bus.load = 1'b1; bus.load_val = WIDTH'(-5); tick(1);
    check("pri_pos", bus.pos, 10);
    check("pri_pulse", bus.step_pulse, 0);
    check("pri_dir", bus.step_dir, 0);
    bus.load_val = WIDTH'(40000); tick(1);
    bus.load = 1'b0;
    check("big_pos", bus.pos, 30250);
    check("big_pulse", bus.step_pulse, 1);
    check("big_at_max", bus.at_max, 1);
    check("big_dir", bus.step_dir, 0);
    $display("load priority -> pos %0d", bus.pos);
    bus.up = 1'b0; tick(10);

    // Down joins during the up repeat, which enters lock until both buttons are released.
    do_load(10);
    check("ld10_pulse", bus.step_pulse, 1);
    bus.up = 1'b1;
    tick(7);  check("lk_pos7", bus.pos, 11);
    tick(10); check("lk_pos17", bus.pos, 12);
    tick(5);  check("lk_pos22", bus.pos, 13);
    tick(1);  bus.down = 1'b1;
    tick(4);  check("lk_pos27", bus.pos, 14);
    check("lk_pulse27", bus.step_pulse, 1);
    tick(13); check("lk_pos40", bus.pos, 14);
    bus.down = 1'b0;
    tick(30); check("lk_pos70", bus.pos, 14);
    check("lk_pulse70", bus.step_pulse, 0);
    bus.up = 1'b0; tick(10);
    bus.up = 1'b1; tick(7);
    check("lk_repress_pos", bus.pos, 15);
    check("lk_repress_pulse", bus.step_pulse, 1);
    $display("lock then re-press -> pos %0d", bus.pos);
    bus.up = 1'b0; tick(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
